// File: rtl/spi_command_sequencer.sv
// Buffers host SPI commands in a small FIFO and runs them one at a time on an SPI engine,
// returning captured read data, a read timeout or a length error per command, in order.
module spi_command_sequencer #(
  parameter int DATA_WIDTH            = 32,
  parameter int TRANSACTION_LEN_WIDTH = 6,
  parameter int QUEUE_DEPTH           = 4,
  parameter int TIMEOUT_CYCLES        = 4096,
  parameter int GAP_CYCLES            = 256
) (
  input  logic                             fabric_clk,
  input  logic                             reset_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [TRANSACTION_LEN_WIDTH-1:0] cmd_length,
  input  logic [DATA_WIDTH-1:0]            cmd_data,
  input  logic [DATA_WIDTH-1:0]            cmd_rw_mask,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [1:0]                       rsp_error,
  output logic [TRANSACTION_LEN_WIDTH-1:0] transaction_length,
  output logic [DATA_WIDTH-1:0]            transaction_data,
  output logic [DATA_WIDTH-1:0]            transaction_rw_mask,
  input  logic                             spi_read_valid,
  input  logic [DATA_WIDTH-1:0]            spi_read_data,
  output logic                             busy
);
  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int ENTRY_W = TRANSACTION_LEN_WIDTH + 2 * DATA_WIDTH;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);
  localparam logic [PTR_W:0]   LVL_ONE      = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   LVL_FULL     = (PTR_W + 1)'(QUEUE_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHECK     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_READ = 3'd3,
    WAIT_GAP  = 3'd4,
    RESPOND   = 3'd5
  } state_t;

  logic [ENTRY_W-1:0] mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     level_q, level_d;
  logic               push, pop;

  state_t                           state_q, state_d;
  logic [TRANSACTION_LEN_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0]            data_q, data_d, mask_q, mask_d;
  logic                             has_read_q, has_read_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]            rsp_data_q, rsp_data_d;
  logic [1:0]                       rsp_error_q, rsp_error_d;
  logic [TRANSACTION_LEN_WIDTH-1:0] tx_len_q, tx_len_d;
  logic [DATA_WIDTH-1:0]            tx_data_q, tx_data_d, tx_mask_q, tx_mask_d;

  logic                  len_bad;
  logic [DATA_WIDTH-1:0] field_mask;
  logic                  has_read;

  assign push      = cmd_valid & cmd_ready;
  assign cmd_ready = (level_q != LVL_FULL);
  assign busy      = (level_q != '0) || (state_q != IDLE);

  // Only the top len bits of the mask are transferred; a 0 there means the engine returns read data.
  assign len_bad    = (len_q == '0) || (32'(len_q) > 32'(DATA_WIDTH));
  assign field_mask = ~({DATA_WIDTH{1'b1}} >> len_q);
  assign has_read   = |(field_mask & ~mask_q);

  assign rsp_valid           = rsp_valid_q;
  assign rsp_data            = rsp_data_q;
  assign rsp_error           = rsp_error_q;
  assign transaction_length  = tx_len_q;
  assign transaction_data    = tx_data_q;
  assign transaction_rw_mask = tx_mask_q;

  // Command storage; contents need no reset because the level counter qualifies every read.
  always_ff @(posedge fabric_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_length, cmd_data, cmd_rw_mask};
    end
  end

  // Queue pointer and fill-level update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Sequencer next-state and output logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    data_d      = data_q;
    mask_d      = mask_q;
    has_read_d  = has_read_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    tx_len_d    = '0;
    tx_data_d   = tx_data_q;
    tx_mask_d   = tx_mask_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop                    = 1'b1;
          {len_d, data_d, mask_d} = mem_q[rd_ptr_q];
          state_d                = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (len_bad) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_error_d = 2'b01;
          state_d     = RESPOND;
        end else begin
          has_read_d = has_read;
          tx_len_d   = len_q;
          tx_data_d  = data_q;
          tx_mask_d  = mask_q;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = has_read_q ? WAIT_READ : WAIT_GAP;
      end
      WAIT_READ: begin
        if (spi_read_valid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = spi_read_data;
          rsp_error_d = 2'b00;
          state_d     = RESPOND;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_error_d = 2'b10;
          state_d     = RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_GAP: begin
        if (cnt_q == GAP_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_error_d = 2'b00;
          state_d     = RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESPOND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge fabric_clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= IDLE;
      len_q       <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      has_read_q  <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 2'b00;
      tx_len_q    <= '0;
      tx_data_q   <= '0;
      tx_mask_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      len_q       <= len_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      has_read_q  <= has_read_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      tx_len_q    <= tx_len_d;
      tx_data_q   <= tx_data_d;
      tx_mask_q   <= tx_mask_d;
    end
  end

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Randomized self-checking bench for spi_command_sequencer against a command-level reference model.
module tb_spi_command_sequencer;
  localparam int DW  = 32;
  localparam int LW  = 6;
  localparam int TMO = 4096;
  localparam int GAP = 256;

  logic          fabric_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_length = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [DW-1:0] cmd_rw_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_error;
  logic [LW-1:0] transaction_length;
  logic [DW-1:0] transaction_data;
  logic [DW-1:0] transaction_rw_mask;
  logic          spi_read_valid = 1'b0;
  logic [DW-1:0] spi_read_data = '0;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int unsigned pcyc = 0;

  typedef struct {
    int unsigned   cyc;
    logic [LW-1:0] len;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
  } pulse_t;
  pulse_t pulses[$];
  pulse_t mon_p;

  spi_command_sequencer #(
    .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW), .QUEUE_DEPTH(4),
    .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
  ) dut (
    .fabric_clk(fabric_clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_length(cmd_length),
    .cmd_data(cmd_data), .cmd_rw_mask(cmd_rw_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .transaction_length(transaction_length), .transaction_data(transaction_data),
    .transaction_rw_mask(transaction_rw_mask),
    .spi_read_valid(spi_read_valid), .spi_read_data(spi_read_data), .busy(busy)
  );

  always #5 fabric_clk = ~fabric_clk;

  always @(posedge fabric_clk) pcyc <= pcyc + 1;

  // Records every cycle in which the engine sees a nonzero transaction length.
  always @(negedge fabric_clk) begin
    if (transaction_length != '0) begin
      mon_p.cyc  = pcyc;
      mon_p.len  = transaction_length;
      mon_p.data = transaction_data;
      mon_p.mask = transaction_rw_mask;
      pulses.push_back(mon_p);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_val({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    check_val({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
    check_val({tag, "_tx_len"}, 64'(transaction_length), 64'd0);
    check_val({tag, "_tx_data"}, 64'(transaction_data), 64'd0);
    check_val({tag, "_tx_mask"}, 64'(transaction_rw_mask), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  // Called at a falling edge; returns the cycle number just after the accepting rising edge.
  task automatic send_cmd(input logic [LW-1:0] len, input logic [DW-1:0] data,
                          input logic [DW-1:0] mask, output int unsigned acc);
    int waited = 0;
    while (!cmd_ready && waited < 20000) begin
      @(negedge fabric_clk);
      waited++;
    end
    if (!cmd_ready) check_val("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid   = 1'b1;
    cmd_length  = len;
    cmd_data    = data;
    cmd_rw_mask = mask;
    @(negedge fabric_clk);
    cmd_valid = 1'b0;
    acc = pcyc;
  endtask

  // One command through an idle sequencer; rd_delay=0 means the engine never answers.
  task automatic run_one(input logic [LW-1:0] len, input logic [DW-1:0] data,
                         input logic [DW-1:0] mask, input int rd_delay, input logic [DW-1:0] rd_word);
    logic bad, has_read, seen;
    int unsigned acc, exp_off;
    logic [DW-1:0] exp_data;
    logic [1:0] exp_err;
    int n0, hold;
    pulse_t p;
    bad = (len == '0) || (int'(len) > DW);
    has_read = 1'b0;
    if (!bad) begin
      for (int b = 0; b < int'(len); b++) if (mask[DW-1-b] == 1'b0) has_read = 1'b1;
    end
    if (bad) begin
      exp_off = 2; exp_data = '0; exp_err = 2'b01;
    end else if (!has_read) begin
      exp_off = 3 + GAP; exp_data = '0; exp_err = 2'b00;
    end else if (rd_delay != 0 && rd_delay <= TMO) begin
      exp_off = 3 + rd_delay; exp_data = rd_word; exp_err = 2'b00;
    end else begin
      exp_off = 3 + TMO; exp_data = '0; exp_err = 2'b10;
    end
    n0 = pulses.size();
    rsp_ready = 1'b0;
    send_cmd(len, data, mask, acc);
    seen = 1'b0;
    while (!seen && pcyc < acc + exp_off + 50) begin
      spi_read_valid = (rd_delay != 0) && (pcyc == acc + 2 + rd_delay);
      spi_read_data  = rd_word;
      @(negedge fabric_clk);
      if (rsp_valid) seen = 1'b1;
    end
    spi_read_valid = 1'b0;
    check_val("rsp_latency", 64'(pcyc - acc), 64'(exp_off));
    check_val("rsp_data", 64'(rsp_data), 64'(exp_data));
    check_val("rsp_error", 64'(rsp_error), 64'(exp_err));
    hold = $urandom_range(1, 3);
    for (int h = 0; h < hold; h++) begin
      spi_read_valid = (h == 0);
      spi_read_data  = 32'hDEAD_BEEF;
      @(negedge fabric_clk);
    end
    spi_read_valid = 1'b0;
    check_val("rsp_hold_valid", 64'(rsp_valid), 64'd1);
    check_val("rsp_hold_data", 64'(rsp_data), 64'(exp_data));
    check_val("rsp_hold_error", 64'(rsp_error), 64'(exp_err));
    check_val("pulse_count", 64'(pulses.size() - n0), bad ? 64'd0 : 64'd1);
    if (pulses.size() > n0) begin
      p = pulses[n0];
      check_val("pulse_latency", 64'(p.cyc - acc), 64'd2);
      check_val("pulse_len", 64'(p.len), 64'(len));
      check_val("pulse_data", 64'(p.data), 64'(data));
      check_val("pulse_mask", 64'(p.mask), 64'(mask));
    end
    rsp_ready = 1'b1;
    @(negedge fabric_clk);
    rsp_ready = 1'b0;
    check_val("rsp_drop", 64'(rsp_valid), 64'd0);
    check_val("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int unsigned acc, acc2;
    int n0, got, guard, after_rst;
    logic rsp_seen;
    logic [LW-1:0] bp_len [5];
    logic [DW-1:0] bp_data [5];
    int k;

    repeat (3) @(negedge fabric_clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge fabric_clk);
    check_val("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);

    run_one(6'd8, 32'hA500_0000, 32'hFF00_0000, 0, '0);
    run_one(6'd16, 32'h1234_5678, 32'hFF00_0000, 100, 32'h0000_12AB);
    run_one(6'd16, 32'h0F0F_0000, 32'hFF00_0000, TMO + 7, 32'h7777_7777);
    run_one(6'd16, 32'h0F0F_0000, 32'hFFFF_0000, 0, '0);
    run_one(6'd12, 32'h00AA_0000, 32'hFFF0_0000, TMO, 32'hCAFE_F00D);
    run_one(6'd0, 32'h1111_1111, 32'hFFFF_FFFF, 5, 32'h1);
    run_one(6'd33, 32'h2222_2222, 32'hFFFF_FFFF, 5, 32'h1);
    run_one(6'd32, 32'h3333_3333, 32'hFFFF_FFFE, 1, 32'h4444_4444);
    run_one(6'd1, 32'h8000_0000, 32'h8000_0000, 3, 32'h1);

    for (int i = 0; i < 24; i++) begin
      run_one(6'($urandom_range(0, 40)), $urandom, $urandom, $urandom_range(1, 300), $urandom);
    end

    // Backpressure: five commands while responses are held off, one of them malformed.
    rsp_ready = 1'b0;
    n0 = pulses.size();
    for (int i = 0; i < 5; i++) begin
      bp_len[i]  = (i == 2) ? 6'd0 : 6'd8;
      bp_data[i] = 32'hB000_0000 + 32'(i);
      send_cmd(bp_len[i], bp_data[i], 32'hFF00_0000, acc);
    end
    check_val("bp_cmd_ready_full", 64'(cmd_ready), 64'd0);
    check_val("bp_busy", 64'(busy), 64'd1);
    rsp_ready = 1'b1;
    got = 0;
    guard = 0;
    while (got < 5 && guard < 5 * (GAP + 20)) begin
      if (rsp_valid) begin
        check_val($sformatf("bp_rsp%0d_err", got), 64'(rsp_error), (got == 2) ? 64'd1 : 64'd0);
        check_val($sformatf("bp_rsp%0d_data", got), 64'(rsp_data), 64'd0);
        got++;
      end
      @(negedge fabric_clk);
      guard++;
    end
    rsp_ready = 1'b0;
    check_val("bp_rsp_count", 64'(got), 64'd5);
    check_val("bp_pulse_count", 64'(pulses.size() - n0), 64'd4);
    k = n0;
    for (int i = 0; i < 5; i++) begin
      if (bp_len[i] != '0 && k < pulses.size()) begin
        check_val($sformatf("bp_order%0d", i), 64'(pulses[k].data), 64'(bp_data[i]));
        k++;
      end
    end
    check_val("bp_end_ready", 64'(cmd_ready), 64'd1);
    check_val("bp_end_busy", 64'(busy), 64'd0);

    // Reset while a read is outstanding and another command is queued.
    n0 = pulses.size();
    send_cmd(6'd16, 32'h5555_0000, 32'hFF00_0000, acc);
    repeat (40) @(negedge fabric_clk);
    send_cmd(6'd8, 32'h0000_0001, 32'hFF00_0000, acc2);
    check_val("mid_busy", 64'(busy), 64'd1);
    check_val("mid_tx_data", 64'(transaction_data), 64'h5555_0000);
    reset_n = 1'b0;
    @(negedge fabric_clk);
    check_reset_outputs("mid_reset");
    reset_n = 1'b1;
    check_val("mid_pulse_count", 64'(pulses.size() - n0), 64'd1);
    after_rst = pulses.size();
    rsp_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      spi_read_valid = (i == 5);
      spi_read_data  = 32'h0BAD_0BAD;
      @(negedge fabric_clk);
      if (rsp_valid) rsp_seen = 1'b1;
    end
    spi_read_valid = 1'b0;
    check_val("post_rst_pulses", 64'(pulses.size() - after_rst), 64'd0);
    check_val("post_rst_rsp", 64'(rsp_seen), 64'd0);
    check_val("post_rst_busy", 64'(busy), 64'd0);
    check_val("post_rst_ready", 64'(cmd_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
